// File: rtl/id_stage_hz.sv
// Decode stage: register file with optional write-to-read bypass, immediate
// generation, control decode, load-use interlock and the ID/EX pipeline register.
module id_stage_hz #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  parameter int HAZARD = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  input  logic            ex_flush,
  input  logic            ex_stall,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_regwen,
  output logic            ex_memwen,
  output logic            ex_illegal,
  output logic [15:0]     stall_cnt
);

  localparam int AW = $clog2(NREG);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            regwen;
    logic            memwen;
    logic            illegal;
  } idex_t;

  logic [XLEN-1:0] regs_q [NREG-1:1];
  logic [XLEN-1:0] regs_d [NREG-1:1];
  idex_t           idex_q, idex_d, dec;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1_idx, rs2_idx;
  logic            uses_rs1, uses_rs2, legal, hazard;
  logic [31:0]     imm32;
  logic [XLEN-1:0] rs1_data, rs2_data;

  always_comb begin
    regs_d = regs_q;
    if (wb_we && wb_rd != 5'd0 && int'(wb_rd) < NREG)
      regs_d[wb_rd[AW-1:0]] = wb_data;
  end

  always_comb begin
    opcode   = if_inst[6:0];
    rd       = if_inst[11:7];
    uses_rs1 = !(opcode inside {OP_JAL, OP_LUI, OP_AUIPC});
    uses_rs2 = opcode inside {OP_REG, OP_STORE, OP_BRANCH};
    rs1_idx  = uses_rs1 ? if_inst[19:15] : 5'd0;
    rs2_idx  = uses_rs2 ? if_inst[24:20] : 5'd0;
    legal    = opcode inside {OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                              OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  end

  // Index 0 and indices beyond NREG read as zero, which also covers unused operands.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_idx != 5'd0 && int'(rs1_idx) < NREG) begin
      if (BYPASS != 0 && wb_we && wb_rd == rs1_idx) rs1_data = wb_data;
      else                                          rs1_data = regs_q[rs1_idx[AW-1:0]];
    end
    if (rs2_idx != 5'd0 && int'(rs2_idx) < NREG) begin
      if (BYPASS != 0 && wb_we && wb_rd == rs2_idx) rs2_data = wb_data;
      else                                          rs2_data = regs_q[rs2_idx[AW-1:0]];
    end
  end

  always_comb begin
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
      OP_STORE:  imm32 = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
      OP_BRANCH: imm32 = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25],
                          if_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm32 = {if_inst[31:12], 12'd0};
      OP_JAL:    imm32 = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20],
                          if_inst[30:21], 1'b0};
      default:   imm32 = '0;
    endcase
  end

  always_comb begin
    dec          = '0;
    dec.valid    = 1'b1;
    dec.pc       = if_pc;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.imm      = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
    dec.rs1      = rs1_idx;
    dec.rs2      = rs2_idx;
    dec.rd       = rd;
    dec.opcode   = opcode;
    dec.funct3   = if_inst[14:12];
    dec.funct7b5 = if_inst[30];
    dec.regwen   = legal && (rd != 5'd0) &&
                   (opcode inside {OP_REG, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC});
    dec.memwen   = (opcode == OP_STORE);
    dec.illegal  = !legal;
    if (!if_valid) dec = '0;
  end

  always_comb begin
    hazard = (HAZARD != 0) && idex_q.valid && (idex_q.opcode == OP_LOAD) &&
             (idex_q.rd != 5'd0) && if_valid &&
             ((uses_rs1 && if_inst[19:15] == idex_q.rd) ||
              (uses_rs2 && if_inst[24:20] == idex_q.rd));
    id_stall = (hazard || ex_stall) && !ex_flush && !reset;
  end

  // Priority: flush, then downstream hold, then load-use bubble, then normal load.
  always_comb begin
    idex_d      = idex_q;
    stall_cnt_d = stall_cnt_q;
    if (ex_flush) begin
      idex_d = '0;
    end else if (!ex_stall) begin
      if (hazard) begin
        idex_d = '0;
        if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
        idex_d = dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q      <= '{default: '0};
      idex_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      regs_q      <= regs_d;
      idex_q      <= idex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid    = idex_q.valid;
  assign ex_pc       = idex_q.pc;
  assign ex_rs1_data = idex_q.rs1_data;
  assign ex_rs2_data = idex_q.rs2_data;
  assign ex_imm      = idex_q.imm;
  assign ex_rs1      = idex_q.rs1;
  assign ex_rs2      = idex_q.rs2;
  assign ex_rd       = idex_q.rd;
  assign ex_opcode   = idex_q.opcode;
  assign ex_funct3   = idex_q.funct3;
  assign ex_funct7b5 = idex_q.funct7b5;
  assign ex_regwen   = idex_q.regwen;
  assign ex_memwen   = idex_q.memwen;
  assign ex_illegal  = idex_q.illegal;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// Scoreboard bench for id_stage_hz: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_id_stage_hz;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b5, regwen, memwen, illegal;
    logic [15:0] cnt;
  } ex_t;

  typedef struct { ex_t e; bit chk; string name; } reg_exp_t;
  typedef struct { logic s; bit chk; string name; } comb_exp_t;

  localparam logic [31:0] I_ADD_6_5_0 = 32'h00028333;
  localparam logic [31:0] I_ADDI_7    = 32'h00508393;
  localparam logic [31:0] I_LW_5_1    = 32'h0000A283;
  localparam logic [31:0] I_ADD_6_5_7 = 32'h00728333;
  localparam logic [31:0] I_BEQ       = 32'hFE000EE3;
  localparam logic [31:0] I_ADDI_X0   = 32'h00100013;
  localparam logic [31:0] I_SW        = 32'h0070A423;
  localparam logic [31:0] I_ILL       = 32'h000001FF;
  localparam logic [31:0] I_LUI       = 32'h123454B7;
  localparam logic [31:0] I_JAL       = 32'hFF9FF0EF;
  localparam logic [31:0] I_LW_5_5    = 32'h0002A283;

  logic        clk = 1'b0;
  logic        reset, if_valid, ex_flush, ex_stall, wb_we;
  logic [31:0] if_inst, if_pc, wb_data;
  logic [4:0]  wb_rd;
  logic        id_stall, ex_valid, ex_funct7b5, ex_regwen, ex_memwen, ex_illegal;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [15:0] stall_cnt;

  id_stage_hz dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .ex_flush(ex_flush), .ex_stall(ex_stall), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_regwen(ex_regwen),
    .ex_memwen(ex_memwen), .ex_illegal(ex_illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  ex_t act;
  assign act = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                ex_opcode, ex_funct3, ex_funct7b5, ex_regwen, ex_memwen, ex_illegal, stall_cnt};

  reg_exp_t  q_reg[$];
  comb_exp_t q_comb[$];
  int        checks = 0;
  int        errors = 0;
  logic      end_req = 1'b0;

  function automatic ex_t mk(input logic [31:0] pc, r1d, r2d, imm,
                             input logic [4:0] r1, r2, rd, input logic [6:0] opc,
                             input logic [2:0] f3, input logic f7, rw, mw, il,
                             input logic [15:0] cnt);
    mk = '{valid: 1'b1, pc: pc, rs1d: r1d, rs2d: r2d, imm: imm, rs1: r1, rs2: r2, rd: rd,
           opc: opc, f3: f3, f7b5: f7, regwen: rw, memwen: mw, illegal: il, cnt: cnt};
  endfunction

  function automatic ex_t bub(input logic [15:0] cnt);
    bub = '0;
    bub.cnt = cnt;
  endfunction

  // Called 1 time unit after a rising edge: applies inputs for this cycle.
  task automatic drive(input string nm, input logic rst, iv, input logic [31:0] inst, pc,
                       input logic fl, st, we, input logic [4:0] rd, input logic [31:0] data,
                       input logic exp_stall, input ex_t exp, input bit chk);
    reset = rst; if_valid = iv; if_inst = inst; if_pc = pc;
    ex_flush = fl; ex_stall = st; wb_we = we; wb_rd = rd; wb_data = data;
    q_comb.push_back('{s: exp_stall, chk: chk, name: nm});
    @(posedge clk);
    q_reg.push_back('{e: exp, chk: chk, name: nm});
    #1;
  endtask

  always @(negedge clk) begin
    while (q_reg.size() > 0) begin
      reg_exp_t r;
      r = q_reg.pop_front();
      if (r.chk) begin
        checks++;
        if (act !== r.e) begin
          errors++;
          $display("FAIL %s: ex outputs got %h want %h", r.name, act, r.e);
        end
      end
    end
    while (q_comb.size() > 0) begin
      comb_exp_t c;
      c = q_comb.pop_front();
      if (c.chk) begin
        checks++;
        if (id_stall !== c.s) begin
          errors++;
          $display("FAIL %s: id_stall got %b want %b", c.name, id_stall, c.s);
        end
      end
    end
    if (end_req) begin
      checks++;
      if (q_reg.size() != 0 || q_comb.size() != 0) begin
        errors++;
        $display("FAIL drain: pending reg=%0d comb=%0d want 0", q_reg.size(), q_comb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0;
    ex_flush = 1'b0; ex_stall = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    @(posedge clk); #1;

    drive("reset0", 1, 1, I_ADD_6_5_7, 32'h0, 0, 1, 0, 5'd0, 32'h0, 0, bub(0), 1);
    drive("reset1", 1, 1, I_ADD_6_5_7, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0, bub(0), 1);
    drive("wb_x1", 0, 0, 32'h0, 32'h0, 0, 0, 1, 5'd1, 32'h100, 0, bub(0), 1);
    drive("bypass_rs1", 0, 1, I_ADD_6_5_0, 32'h10, 0, 0, 1, 5'd5, 32'h1234, 0,
          mk(32'h10, 32'h1234, 0, 0, 5, 0, 6, 7'h33, 0, 0, 1, 0, 0, 0), 1);
    drive("addi", 0, 1, I_ADDI_7, 32'h14, 0, 0, 1, 5'd7, 32'h77, 0,
          mk(32'h14, 32'h100, 0, 5, 1, 0, 7, 7'h13, 0, 0, 1, 0, 0, 0), 1);
    drive("lw", 0, 1, I_LW_5_1, 32'h18, 0, 0, 0, 5'd0, 32'h0, 0,
          mk(32'h18, 32'h100, 0, 0, 1, 0, 5, 7'h03, 2, 0, 1, 0, 0, 0), 1);
    drive("load_use", 0, 1, I_ADD_6_5_7, 32'h1C, 0, 0, 0, 5'd0, 32'h0, 1, bub(1), 1);
    drive("after_bubble", 0, 1, I_ADD_6_5_7, 32'h1C, 0, 0, 1, 5'd5, 32'h55, 0,
          mk(32'h1C, 32'h55, 32'h77, 0, 5, 7, 6, 7'h33, 0, 0, 1, 0, 0, 1), 1);
    drive("lw2", 0, 1, I_LW_5_1, 32'h20, 0, 0, 0, 5'd0, 32'h0, 0,
          mk(32'h20, 32'h100, 0, 0, 1, 0, 5, 7'h03, 2, 0, 1, 0, 0, 1), 1);
    drive("flush_hazard", 0, 1, I_ADD_6_5_7, 32'h24, 1, 0, 0, 5'd0, 32'h0, 0, bub(1), 1);
    drive("beq", 0, 1, I_BEQ, 32'h28, 0, 0, 0, 5'd0, 32'h0, 0,
          mk(32'h28, 0, 0, 32'hFFFFFFFC, 0, 0, 29, 7'h63, 0, 1, 0, 0, 0, 1), 1);
    drive("addi_x0", 0, 1, I_ADDI_X0, 32'h2C, 0, 0, 0, 5'd0, 32'h0, 0,
          mk(32'h2C, 0, 0, 1, 0, 0, 0, 7'h13, 0, 0, 0, 0, 0, 1), 1);
    drive("sw", 0, 1, I_SW, 32'h30, 0, 0, 0, 5'd0, 32'h0, 0,
          mk(32'h30, 32'h100, 32'h77, 8, 1, 7, 8, 7'h23, 2, 0, 0, 1, 0, 1), 1);
    drive("illegal", 0, 1, I_ILL, 32'h34, 0, 0, 0, 5'd0, 32'h0, 0,
          mk(32'h34, 0, 0, 0, 0, 0, 3, 7'h7F, 0, 0, 0, 0, 1, 1), 1);
    for (int i = 0; i < 3; i++)
      drive("ex_stall_hold", 0, 1, I_LUI, 32'h38, 0, 1, 0, 5'd0, 32'h0, 1,
            mk(32'h34, 0, 0, 0, 0, 0, 3, 7'h7F, 0, 0, 0, 0, 1, 1), 1);
    drive("lui", 0, 1, I_LUI, 32'h38, 0, 0, 0, 5'd0, 32'h0, 0,
          mk(32'h38, 0, 0, 32'h12345000, 0, 0, 9, 7'h37, 5, 0, 1, 0, 0, 1), 1);
    drive("jal", 0, 1, I_JAL, 32'h3C, 0, 0, 0, 5'd0, 32'h0, 0,
          mk(32'h3C, 0, 0, 32'hFFFFFFF8, 0, 0, 1, 7'h6F, 7, 1, 1, 0, 0, 1), 1);
    drive("no_inst", 0, 0, I_ADD_6_5_7, 32'h40, 0, 0, 0, 5'd0, 32'h0, 0, bub(1), 1);

    // Counter saturation: alternate load / dependent re-fetch of the same lw.
    drive("sat_reset", 1, 0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0, bub(0), 1);
    drive("sat_load", 0, 1, I_LW_5_5, 32'h100, 0, 0, 0, 5'd0, 32'h0, 0,
          mk(32'h100, 0, 0, 0, 5, 0, 5, 7'h03, 2, 0, 1, 0, 0, 0), 1);
    drive("sat_hazard", 0, 1, I_LW_5_5, 32'h100, 0, 0, 0, 5'd0, 32'h0, 1, bub(1), 1);
    for (int i = 2; i <= 65540; i++) begin
      drive("sat_loop_load", 0, 1, I_LW_5_5, 32'h100, 0, 0, 0, 5'd0, 32'h0, 0, bub(0), 0);
      drive("sat_final", 0, 1, I_LW_5_5, 32'h100, 0, 0, 0, 5'd0, 32'h0, 1,
            bub(16'hFFFF), (i == 65540));
    end
    drive("sat_reload", 0, 1, I_LW_5_5, 32'h100, 0, 0, 1, 5'd5, 32'hABC, 0,
          mk(32'h100, 32'hABC, 0, 0, 5, 0, 5, 7'h03, 2, 0, 1, 0, 0, 16'hFFFF), 1);
    drive("reset_in_hazard", 1, 1, I_LW_5_5, 32'h100, 0, 0, 0, 5'd0, 32'h0, 0, bub(0), 1);
    drive("regs_cleared", 0, 1, I_ADD_6_5_0, 32'h200, 0, 0, 0, 5'd0, 32'h0, 0,
          mk(32'h200, 0, 0, 0, 5, 0, 6, 7'h33, 0, 0, 1, 0, 0, 0), 1);

    if_valid = 1'b0;
    end_req = 1'b1;
    repeat (5) @(posedge clk);
  end

endmodule
